// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//
// Turns the byte stream from the serial receiver into register-bus strobes.
// The line protocol is strict ASCII hex:
//   "W<addr><data>\n"  write  (exactly ADDR_W/4 and DATA_W/4 hex digits)
//   "R<addr>\n"        read request
// The command letters may be upper or lower case. CR is ignored anywhere in
// a line. LF always ends the line. A line that does not match the protocol
// is thrown away and reported with a single err pulse. An empty line is
// ignored quietly.
//
// Ports
//   CLK      system clock
//   RST      asynchronous active-low reset
//   rx_flag  one-cycle "byte complete" pulse from the receiver
//   rx_char  received byte, valid from the cycle after rx_flag
//   wr_en    one-cycle write strobe
//   rd_en    one-cycle read-request strobe
//   addr     command address, held from one strobe to the next
//   wdata    write data, updated only together with wr_en
//   err      one-cycle pulse when a line is rejected
//   busy     high while a line is partly parsed
module uart_cmd_parser #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx_flag,
  input  logic [7:0]        rx_char,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              err,
  output logic              busy
);

  localparam int ADDR_DIG = ADDR_W / 4;
  localparam int DATA_DIG = DATA_W / 4;
  localparam int MAX_DIG  = (ADDR_DIG > DATA_DIG) ? ADDR_DIG : DATA_DIG;
  localparam int CNT_W    = $clog2(MAX_DIG + 1);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_FLUSH
  } state_t;

  state_t            state, state_nxt;
  logic              flag_d;
  logic              op_wr, op_wr_nxt;      // 1 = write line, 0 = read line
  logic [CNT_W-1:0]  cnt, cnt_nxt;          // digits taken in the current field
  logic [ADDR_W-1:0] addr_sh, addr_sh_nxt;
  logic [DATA_W-1:0] data_sh, data_sh_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              wr_nxt, rd_nxt, err_nxt;

  logic              is_hex;
  logic [3:0]        nib;
  logic              is_lf, is_cr;
  logic              addr_full, data_full;

  // Hex decode. For 'A'-'F' and 'a'-'f' the low nibble of the character
  // code is 1..6, so adding 9 gives 10..15.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (rx_char >= 8'h30 && rx_char <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_char[3:0];
    end else if ((rx_char >= 8'h41 && rx_char <= 8'h46) ||
                 (rx_char >= 8'h61 && rx_char <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_char[3:0] + 4'd9;
    end
  end

  assign is_lf     = (rx_char == CH_LF);
  assign is_cr     = (rx_char == CH_CR);
  assign addr_full = (cnt == CNT_W'(ADDR_DIG));
  assign data_full = (cnt == CNT_W'(DATA_DIG));

  // Next-state and strobe logic. A byte is acted on only in the cycle after
  // rx_flag (flag_d high), so each byte is taken exactly once.
  // NOTE: every signal assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    op_wr_nxt   = op_wr;
    cnt_nxt     = cnt;
    addr_sh_nxt = addr_sh;
    data_sh_nxt = data_sh;
    addr_nxt    = addr;
    wdata_nxt   = wdata;
    wr_nxt      = 1'b0;
    rd_nxt      = 1'b0;
    err_nxt     = 1'b0;

    if (flag_d && !is_cr) begin
      unique case (state)
        S_IDLE: begin
          if (rx_char == "W" || rx_char == "w" ||
              rx_char == "R" || rx_char == "r") begin
            state_nxt   = S_ADDR;
            op_wr_nxt   = (rx_char == "W" || rx_char == "w");
            cnt_nxt     = '0;
            addr_sh_nxt = '0;
          end else if (!is_lf) begin
            state_nxt = S_FLUSH;
          end
          // A bare LF is an empty line: no pulse, stay idle.
        end

        S_ADDR: begin
          if (!addr_full) begin
            if (is_hex) begin
              addr_sh_nxt = (addr_sh << 4) | ADDR_W'(nib);
              cnt_nxt     = cnt + CNT_W'(1);
            end else if (is_lf) begin
              state_nxt = S_IDLE;
              err_nxt   = 1'b1;
            end else begin
              state_nxt = S_FLUSH;
            end
          end else if (op_wr && is_hex) begin
            // The first data digit arrives here and starts the data field.
            state_nxt   = S_DATA;
            data_sh_nxt = DATA_W'(nib);
            cnt_nxt     = CNT_W'(1);
          end else if (!op_wr && is_lf) begin
            state_nxt = S_IDLE;
            rd_nxt    = 1'b1;
            addr_nxt  = addr_sh;
          end else if (is_lf) begin
            // Write line with no data field.
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = S_FLUSH;
          end
        end

        S_DATA: begin
          if (!data_full) begin
            if (is_hex) begin
              data_sh_nxt = (data_sh << 4) | DATA_W'(nib);
              cnt_nxt     = cnt + CNT_W'(1);
            end else if (is_lf) begin
              state_nxt = S_IDLE;
              err_nxt   = 1'b1;
            end else begin
              state_nxt = S_FLUSH;
            end
          end else if (is_lf) begin
            state_nxt = S_IDLE;
            wr_nxt    = 1'b1;
            addr_nxt  = addr_sh;
            wdata_nxt = data_sh;
          end else begin
            state_nxt = S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (is_lf) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // flag_d is a plain delay of rx_flag with no gating, so a new pulse is
  // never lost even if it lands while the previous byte is being taken.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      flag_d  <= 1'b0;
      op_wr   <= 1'b0;
      cnt     <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      addr    <= '0;
      wdata   <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      flag_d  <= rx_flag;
      op_wr   <= op_wr_nxt;
      cnt     <= cnt_nxt;
      addr_sh <= addr_sh_nxt;
      data_sh <= data_sh_nxt;
      addr    <= addr_nxt;
      wdata   <= wdata_nxt;
      wr_en   <= wr_nxt;
      rd_en   <= rd_nxt;
      err     <= err_nxt;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser.
// Stimulus pushes the expected strobe (kind, addr, wdata, cycle) into a
// scoreboard queue when it sends the terminating LF; a monitor pops and
// compares whenever the DUT raises wr_en, rd_en or err.
module tb_uart_cmd_parser;

  localparam int GAP = 12;  // idle cycles between received bytes

  localparam logic [2:0] K_WR  = 3'b100;
  localparam logic [2:0] K_RD  = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;
  localparam logic [2:0] K_NONE = 3'b000;

  logic       CLK;
  logic       RST;
  logic       rx_flag;
  logic [7:0] rx_char;
  logic       wr_en, rd_en, err, busy;
  logic [7:0] addr, wdata;

  uart_cmd_parser #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .rx_flag (rx_flag),
    .rx_char (rx_char),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .err     (err),
    .busy    (busy)
  );

  typedef struct {
    logic [2:0] kind;
    logic [7:0] a;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge CLK) begin
    if (RST === 1'b1 && (wr_en || rd_en || err)) begin
      check("strobe_mutex", 32'(wr_en) + 32'(rd_en) + 32'(err), 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, wr_en, rd_en, err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind",  {29'd0, wr_en, rd_en, err}, {29'd0, e.kind});
        check("strobe_addr",  32'(addr),  32'(e.a));
        check("strobe_wdata", 32'(wdata), 32'(e.d));
        check("strobe_cycle", 32'(cyc),   32'(e.due));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    rx_char = b;
    rx_flag = 1'b1;
    @(posedge CLK);
    #1;
    rx_flag = 1'b0;
    repeat (GAP) @(posedge CLK);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Sends LF; the strobe it causes is due two cycles after its rx_flag.
  task automatic send_lf(input logic [2:0] kind, input logic [7:0] a,
                         input logic [7:0] d);
    exp_t e;
    @(posedge CLK);
    #1;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.a    = a;
      e.d    = d;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    rx_char = 8'h0A;
    rx_flag = 1'b1;
    @(posedge CLK);
    #1;
    rx_flag = 1'b0;
    repeat (GAP) @(posedge CLK);
  endtask

  initial begin
    RST     = 1'b0;
    rx_flag = 1'b0;
    rx_char = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // Reset state
    check("rst_outputs", {28'd0, wr_en, rd_en, err, busy}, 0);
    check("rst_addr",  32'(addr),  0);
    check("rst_wdata", 32'(wdata), 0);

    // Plain write
    send_str("W3CA5");
    send_lf(K_WR, 8'h3C, 8'hA5);

    // Lower-case read with CR before LF; wdata keeps 0xA5
    send_str("r0f");
    send_byte(8'h0D);
    send_lf(K_RD, 8'h0F, 8'hA5);

    // Non-hex inside the address: busy through the line, err at LF
    send_byte("W");
    check("busy_after_W", 32'(busy), 1);
    send_str("3G1");
    check("busy_in_flush", 32'(busy), 1);
    send_str("2");
    send_lf(K_ERR, 8'h0F, 8'hA5);
    check("busy_after_lf", 32'(busy), 0);
    check("hold_addr",  32'(addr),  32'h0F);
    check("hold_wdata", 32'(wdata), 32'hA5);

    // Overlong data field, then short line, then a good write
    send_str("W12345");
    send_lf(K_ERR, 8'h0F, 8'hA5);
    send_str("W12");
    send_lf(K_ERR, 8'h0F, 8'hA5);
    send_str("W0102");
    send_lf(K_WR, 8'h01, 8'h02);

    // Overlong read address and a junk command letter
    send_str("R123");
    send_lf(K_ERR, 8'h01, 8'h02);
    send_str("Q");
    send_lf(K_ERR, 8'h01, 8'h02);

    // Empty lines: no pulses, never busy
    send_lf(K_NONE, 8'h00, 8'h00);
    check("empty_busy1", 32'(busy), 0);
    send_lf(K_NONE, 8'h00, 8'h00);
    check("empty_busy2", 32'(busy), 0);

    // Reset in the middle of a line clears everything at once
    send_str("W12");
    check("busy_before_rst", 32'(busy), 1);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_outputs", {28'd0, wr_en, rd_en, err, busy}, 0);
    check("midrst_addr",  32'(addr),  0);
    check("midrst_wdata", 32'(wdata), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    send_str("R55");
    send_lf(K_RD, 8'h55, 8'h00);

    repeat (20) @(posedge CLK);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
